snn_img_loader: RTL and testbench

- Sits directly downstream of the UART receiver in the SNN top level.
- Consumes received bytes (rx_rdy/rx_data) and packs one 28x28 binary image (784 bits = 98 bytes) into the SNN input image RAM.
- Pulses img_rdy to the SNN core when the image is complete, then holds off further loading until the core reports done.
- Recovers from a broken or partial frame with an inter-byte gap timeout.

---
 rtl/snn_pkg.sv | 14 +
 rtl/snn_gap_timer.sv | 30 +++
 rtl/snn_img_loader.sv | 120 ++++++++++++
 tb/tb_snn_img_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN types and image geometry.
// Used by the image loader, the core and the image RAM.
package snn_pkg;

    localparam int IMG_BYTES  = 98;
    localparam int IMG_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_CORE
    } loader_state_t;

endpackage

// File: rtl/snn_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled,
// flags expiry when the count reaches TIMEOUT_CYC-1.
module snn_gap_timer #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/snn_img_loader.sv
// Packs UART bytes into the SNN image RAM and hands the
// finished image to the core, with a gap timeout for broken frames.
module snn_img_loader
    import snn_pkg::*;
#(
    parameter int NUM_BYTES   = IMG_BYTES,
    parameter int ADDR_W      = IMG_ADDR_W,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              core_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              img_rdy,
    output logic              busy,
    output logic              frame_err,
    output logic              drop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic              we_n, img_n, ferr_n, drop_n;
    logic              gap_exp;

    // Clearing on expiry as well keeps the counter at 0 once back in IDLE.
    snn_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == LOAD),
        .clr   (rx_rdy || gap_exp),
        .expire(gap_exp)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = ram_addr;
        wdata_n = ram_wdata;
        we_n    = 1'b0;
        img_n   = 1'b0;
        ferr_n  = 1'b0;
        drop_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_rdy) begin
                    we_n    = 1'b1;
                    addr_n  = '0;
                    wdata_n = rx_data;
                    cnt_n   = ADDR_W'(1);
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (rx_rdy) begin
                    we_n    = 1'b1;
                    addr_n  = cnt;
                    wdata_n = rx_data;
                    if (cnt == LAST_ADDR) begin
                        cnt_n   = '0;
                        img_n   = 1'b1;
                        state_n = WAIT_CORE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else if (gap_exp) begin
                    ferr_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            WAIT_CORE: begin
                drop_n = rx_rdy;
                if (core_done) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            img_rdy   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ram_we    <= we_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            img_rdy   <= img_n;
            busy      <= (state_n != IDLE);
            frame_err <= ferr_n;
            drop      <= drop_n;
        end
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// Randomised bench for snn_img_loader against a
// timestamp-based frame model.
module tb_snn_img_loader;

    localparam int NB = 98;
    localparam int AW = 7;
    localparam int TO = 100;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          core_done = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          img_rdy;
    logic          busy;
    logic          frame_err;
    logic          drop;

    snn_img_loader #(
        .NUM_BYTES  (NB),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TO),
        .TO_W       (TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .core_done(core_done),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .img_rdy  (img_rdy),
        .busy     (busy),
        .frame_err(frame_err),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = waiting for a frame, 1 = filling, 2 = image held for core
    int     m_phase = 0;
    int     m_next = 0;
    longint cyc = 0;
    longint last_rx = 0;
    bit     e_we, e_img, e_busy, e_fe, e_drop;
    int     e_addr = 0;
    logic [7:0] e_data = 8'h00;
    int     m_imgs = 0;
    int     d_imgs = 0;
    int     m_errs = 0;
    int     d_errs = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {12'd0, ram_we, ram_addr, ram_wdata,
                img_rdy, busy, frame_err, drop};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [AW-1:0] a;
        a = AW'(e_addr);
        return {12'd0, e_we, a, e_data,
                e_img, e_busy, e_fe, e_drop};
    endfunction

    task automatic model(bit rx, logic [7:0] d, bit done);
        cyc++;
        e_we   = 1'b0;
        e_img  = 1'b0;
        e_fe   = 1'b0;
        e_drop = 1'b0;
        if (m_phase == 2) begin
            e_drop = rx;
            if (done) m_phase = 0;
        end else if (rx) begin
            e_we    = 1'b1;
            e_addr  = (m_phase == 0) ? 0 : m_next;
            e_data  = d;
            m_next  = e_addr + 1;
            last_rx = cyc;
            m_phase = 1;
            if (e_addr == NB - 1) begin
                e_img   = 1'b1;
                m_phase = 2;
                m_imgs++;
            end
        end else if (m_phase == 1 && cyc - last_rx == TO) begin
            e_fe    = 1'b1;
            m_phase = 0;
            m_errs++;
        end
        e_busy = (m_phase != 0);
    endtask

    task automatic step(bit rx, bit done, string tag);
        logic [7:0] d;
        d = 8'($urandom);
        @(negedge clk);
        rx_rdy    = rx;
        rx_data   = d;
        core_done = done;
        model(rx, d, done);
        @(posedge clk);
        #1;
        if (img_rdy) d_imgs++;
        if (frame_err) d_errs++;
        check(tag, dut_vec(), exp_vec());
    endtask

    task automatic idle(int n, bit noise, string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, noise && ($urandom_range(0, 15) == 0), tag);
        end
    endtask

    task automatic send(int gap, bit noise, string tag);
        idle(gap, noise, tag);
        step(1'b1, 1'b0, tag);
    endtask

    task automatic send_n(int n, bit noise, string tag);
        for (int i = 0; i < n; i++) begin
            send($urandom_range(0, 60), noise, tag);
        end
    endtask

    task automatic async_reset(string tag);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        rx_rdy    = 1'b0;
        core_done = 1'b0;
        #1;
        check(tag, dut_vec(), 32'd0);
        m_phase = 0;
        m_next  = 0;
        e_we    = 1'b0;
        e_img   = 1'b0;
        e_busy  = 1'b0;
        e_fe    = 1'b0;
        e_drop  = 1'b0;
        e_addr  = 0;
        e_data  = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_hold"}, dut_vec(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check({tag, "_rel"}, dut_vec(), exp_vec());
    endtask

    initial begin
        #1;
        check("reset_out", dut_vec(), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        idle(5, 1'b1, "pre_idle");
        send_n(NB, 1'b1, "frame1");
        check("frame1_img", d_imgs, 1);

        send_n(3, 1'b0, "holdoff");
        step(1'b0, 1'b1, "holdoff_done");
        send(2, 1'b0, "holdoff_addr0");
        check("holdoff_addr", 32'(ram_addr), 32'd0);

        send_n(39, 1'b0, "partial");
        idle(TO + 10, 1'b0, "timeout");
        check("timeout_err", d_errs, 1);
        send_n(NB, 1'b1, "frame2");

        step(1'b0, 1'b1, "race_done");
        send_n(10, 1'b0, "race_pre");
        idle(TO - 1, 1'b0, "race_gap");
        step(1'b1, 1'b0, "race_hit");
        check("race_addr", 32'(ram_addr), 32'd10);
        send_n(NB - 11, 1'b0, "race_rest");

        step(1'b1, 1'b1, "sim_drop");
        send(3, 1'b0, "sim_addr0");
        check("sim_addr", 32'(ram_addr), 32'd0);

        send_n(50, 1'b0, "pre_rst");
        async_reset("mid_rst");
        send_n(NB - 1, 1'b0, "post_rst");
        check("post_rst_noimg", img_rdy, 1'b0);
        send(1, 1'b0, "post_rst_last");

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 399);
            if (r == 0) begin
                idle(TO + $urandom_range(0, 3), 1'b0, "soak_gap");
            end else if (r == 1) begin
                idle(TO - 1, 1'b0, "soak_edge");
            end else begin
                step($urandom_range(0, 2) == 0,
                     $urandom_range(0, 39) == 0, "soak");
            end
        end

        check("img_count", d_imgs, m_imgs);
        check("err_count", d_errs, m_errs);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
